// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types, counter encodings and PC field helpers for the BTB
package btb_pkg;

    localparam int BTB_DATA_WIDTH = 32;
    localparam int BTB_INDEX_BITS = 4;
    localparam int BTB_TAG_BITS   = BTB_DATA_WIDTH - BTB_INDEX_BITS - 2;

    localparam logic [1:0] CTR_SNT   = 2'd0;
    localparam logic [1:0] CTR_WNT   = 2'd1;
    localparam logic [1:0] CTR_WT    = 2'd2;
    localparam logic [1:0] CTR_ST    = 2'd3;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    typedef struct packed {
        logic                      valid;
        logic [BTB_TAG_BITS-1:0]   tag;
        logic [BTB_DATA_WIDTH-1:0] target;
        logic [1:0]                ctr;
    } btb_entry_t;

    // Word-aligned PCs: bits [1:0] never take part in indexing or tagging.
    function automatic logic [BTB_INDEX_BITS-1:0] btb_index(input logic [BTB_DATA_WIDTH-1:0] pc);
        return pc[BTB_INDEX_BITS+1:2];
    endfunction

    function automatic logic [BTB_TAG_BITS-1:0] btb_tag(input logic [BTB_DATA_WIDTH-1:0] pc);
        return pc[BTB_DATA_WIDTH-1:BTB_INDEX_BITS+2];
    endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// rtl/branch_target_buffer_sat_counter2.sv - 2-bit saturating direction counter next-state
module sat_counter2
    import btb_pkg::*;
(
    input  logic [1:0] count,
    input  logic       taken,
    output logic [1:0] next_count
);

    // Step toward the resolved direction, holding at either end.
    always_comb begin
        next_count = count;
        if (taken) begin
            if (count != CTR_ST) begin
                next_count = count + 2'd1;
            end
        end else begin
            if (count != CTR_SNT) begin
                next_count = count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with 2-bit counters and execute mispredict detect
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int DATA_WIDTH = BTB_DATA_WIDTH,
    parameter int INDEX_BITS = BTB_INDEX_BITS
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] PCF,
    output logic                  PredTakenF,
    output logic [DATA_WIDTH-1:0] PredTargetF,
    input  logic                  UpdateE,
    input  logic [DATA_WIDTH-1:0] PCE,
    input  logic                  TakenE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic                  PredTakenE,
    input  logic [DATA_WIDTH-1:0] PredTargetE,
    output logic                  MispredictE,
    output logic [DATA_WIDTH-1:0] RedirectPCE
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    // Flop array: the fetch read must be combinational and reset must clear every valid bit.
    btb_entry_t table_q [ENTRIES];

    logic [BTB_INDEX_BITS-1:0] idx_f;
    logic [BTB_INDEX_BITS-1:0] idx_e;
    btb_entry_t                rd_f;
    btb_entry_t                rd_e;
    logic                      hit_f;
    logic                      hit_e;
    logic [1:0]                ctr_next;

    assign idx_f = btb_index(PCF);
    assign idx_e = btb_index(PCE);
    assign rd_f  = table_q[idx_f];
    assign rd_e  = table_q[idx_e];
    assign hit_f = rd_f.valid && (rd_f.tag == btb_tag(PCF));
    assign hit_e = rd_e.valid && (rd_e.tag == btb_tag(PCE));

    sat_counter2 u_sat_counter2 (
        .count      (rd_e.ctr),
        .taken      (TakenE),
        .next_count (ctr_next)
    );

    // Fetch prediction: pre-update contents, forced not-taken while in reset.
    always_comb begin
        PredTakenF  = rst_n && hit_f && rd_f.ctr[1];
        PredTargetF = PCF + DATA_WIDTH'(4);
        if (PredTakenF) begin
            PredTargetF = rd_f.target;
        end
    end

    // Execute check: wrong direction, or taken to a different target than predicted.
    always_comb begin
        MispredictE = rst_n && UpdateE &&
                      ((PredTakenE != TakenE) || (TakenE && (PredTargetE != PCTargetE)));
        RedirectPCE = TakenE ? PCTargetE : (PCE + DATA_WIDTH'(4));
    end

    // Table update; reset has priority over a concurrent resolve and leaves tags/targets stale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
                table_q[i].ctr   <= CTR_SNT;
            end
        end else if (UpdateE) begin
            if (hit_e) begin
                table_q[idx_e].ctr <= ctr_next;
                if (TakenE) begin
                    table_q[idx_e].target <= PCTargetE;
                end
            end else if (TakenE) begin
                table_q[idx_e].valid  <= 1'b1;
                table_q[idx_e].tag    <= btb_tag(PCE);
                table_q[idx_e].target <= PCTargetE;
                table_q[idx_e].ctr    <= CTR_ALLOC;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - self-checking bench for branch_target_buffer
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        UpdateE;
    logic [31:0] PCE;
    logic        TakenE;
    logic [31:0] PCTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredictE;
    logic [31:0] RedirectPCE;

    int total  = 0;
    int passed = 0;

    // Reference model: one slot per index, counter kept as an integer 0..3.
    bit          m_valid  [16];
    logic [31:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];

    branch_target_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF),
        .UpdateE     (UpdateE),
        .PCE         (PCE),
        .TakenE      (TakenE),
        .PCTargetE   (PCTargetE),
        .PredTakenE  (PredTakenE),
        .PredTargetE (PredTargetE),
        .MispredictE (MispredictE),
        .RedirectPCE (RedirectPCE)
    );

    always #5 clk = ~clk;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> 6));
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return rst_n && m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
        return m_pred_taken(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc);
        PCF = pc;
        #1;
        check({tag, ".taken"},  {31'd0, PredTakenF}, {31'd0, m_pred_taken(pc)});
        check({tag, ".target"}, PredTargetF, m_pred_target(pc));
    endtask

    // Drive one resolve after a rising edge, check the execute outputs, then let it commit.
    task automatic update(input string tag, input logic [31:0] pc, input bit taken,
                          input logic [31:0] tgt, input bit pt, input logic [31:0] ptgt);
        bit          exp_mis;
        logic [31:0] exp_red;
        int          i;
        UpdateE = 1'b1; PCE = pc; TakenE = taken; PCTargetE = tgt;
        PredTakenE = pt; PredTargetE = ptgt;
        #1;
        exp_mis = rst_n && ((pt != taken) || (taken && ptgt != tgt));
        exp_red = taken ? tgt : pc + 32'd4;
        check({tag, ".mispredict"}, {31'd0, MispredictE}, {31'd0, exp_mis});
        check({tag, ".redirect"},   RedirectPCE, exp_red);
        @(posedge clk);
        i = m_idx(pc);
        if (!rst_n) begin
            m_reset();
        end else if (m_hit(pc)) begin
            if (taken) begin
                m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (taken) begin
            m_valid[i] = 1'b1; m_tag[i] = pc >> 6; m_target[i] = tgt; m_ctr[i] = 2;
        end
        #1;
        UpdateE = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        m_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] rtg;
        rst_n = 1'b0; PCF = 32'h100; UpdateE = 1'b0; PCE = '0; TakenE = 1'b0;
        PCTargetE = '0; PredTakenE = 1'b0; PredTargetE = '0;
        m_reset();
        do_reset();

        lookup("rst_0x100", 32'h100);
        lookup("wrap_top", 32'hFFFF_FFFC);

        update("alloc", 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        lookup("alloc_hit", 32'h100);
        update("inc3", 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        update("sat3", 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        lookup("sat3_hit", 32'h100);
        update("nt_a", 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        lookup("ctr2", 32'h100);
        update("nt_b", 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        lookup("ctr1", 32'h100);
        update("nt_c", 32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
        update("nt_d", 32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
        update("nt_mis", 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        update("t_after0", 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        lookup("ctr_low_sat", 32'h100);

        update("jalr_alloc", 32'h300, 1'b1, 32'h400, 1'b0, 32'h304);
        update("jalr_tgt", 32'h300, 1'b1, 32'h480, 1'b1, 32'h400);
        lookup("jalr_new", 32'h300);

        update("alias_a", 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        update("alias_b", 32'h140, 1'b1, 32'h600, 1'b0, 32'h144);
        lookup("alias_miss", 32'h100);
        lookup("alias_hit", 32'h140);

        // Same-cycle lookup and update on one index: fetch sees the old contents.
        PCF = 32'h500;
        UpdateE = 1'b1; PCE = 32'h500; TakenE = 1'b1; PCTargetE = 32'h900;
        PredTakenE = 1'b0; PredTargetE = 32'h504;
        #1;
        check("same_cycle.before", {31'd0, PredTakenF}, 32'd0);
        UpdateE = 1'b0;
        update("same_cycle", 32'h500, 1'b1, 32'h900, 1'b0, 32'h504);
        lookup("same_cycle.after", 32'h500);

        rst_n = 1'b0;
        update("rst_upd", 32'h700, 1'b1, 32'h800, 1'b0, 32'h704);
        rst_n = 1'b1;
        lookup("rst_upd_miss", 32'h700);

        for (int n = 0; n < 20; n++) begin
            rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            rtg = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) begin
                update("rand_upd", rpc, 1'($urandom_range(0, 1)), rtg,
                       m_pred_taken(rpc), m_pred_target(rpc));
            end else begin
                update("rand_upd", rpc, 1'($urandom_range(0, 1)), rtg,
                       1'($urandom_range(0, 1)), {$urandom} & 32'hFFFF_FFFC);
            end
            lookup("rand_look", rpc);
        end

        do_reset();
        lookup("rst2_0x100", 32'h100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Fetch-side consumer of resolved branch/jump targets: a direct-mapped BTB with 2-bit saturating direction counters.
- Execute writes back the resolved outcome and target (the PCTarget value, JALR LSB already cleared). Fetch reads a predicted next-PC in the same cycle.
- Also flags execute-stage mispredictions and supplies the redirect PC.

Parameters:
DATA_WIDTH, 32, PC/target width
INDEX_BITS, 4, log2 of entry count (16 entries)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
PCF  input  DATA_WIDTH  fetch PC for lookup
PredTakenF  output  1  predicted taken for PCF
PredTargetF  output  DATA_WIDTH  predicted next PC (target if taken, else PCF+4)
UpdateE  input  1  execute holds a resolved branch/JAL/JALR this cycle
PCE  input  DATA_WIDTH  PC of the resolved instruction
TakenE  input  1  resolved direction (1 for jumps)
PCTargetE  input  DATA_WIDTH  resolved target from the target adder
PredTakenE  input  1  PredTakenF pipelined to execute
PredTargetE  input  DATA_WIDTH  PredTargetF pipelined to execute
MispredictE  output  1  prediction wrong; fetch must flush and redirect
RedirectPCE  output  DATA_WIDTH  correct next PC when MispredictE=1

Behaviour:
- Index = PC[INDEX_BITS+1:2]. Tag = PC[DATA_WIDTH-1:INDEX_BITS+2]. PC[1:0] ignored.
- Entry fields: valid, tag, target, ctr[1:0].
- Lookup is combinational, zero latency:
  - hit = valid & tag match on PCF's index.
  - PredTakenF = hit & ctr[1].
  - PredTargetF = PredTakenF ? target : PCF+4 (modulo 2^DATA_WIDTH, wraps at top).
- Update is registered, taking effect at the next rising edge when UpdateE=1. hitE is computed on PCE.
  - hitE & TakenE: ctr saturating increment (3 stays 3); target <= PCTargetE.
  - hitE & !TakenE: ctr saturating decrement (0 stays 0); target unchanged.
  - !hitE & TakenE: allocate/overwrite the entry: valid=1, tag from PCE, target=PCTargetE, ctr=2'b10 (weakly taken).
  - !hitE & !TakenE: no change.
- Same-cycle lookup and update on the same index: lookup returns pre-update contents. No bypass.
- MispredictE, combinational:
  - MispredictE = UpdateE & ((PredTakenE != TakenE) | (TakenE & PredTargetE != PCTargetE)).
  - RedirectPCE = TakenE ? PCTargetE : PCE+4.
  - MispredictE = 0 whenever UpdateE = 0. RedirectPCE is don't-care when MispredictE = 0, but is driven by the same formula anyway.
- Reset:
  - While rst_n=0 at a clock edge, all valid bits and ctr fields clear to 0. Tags and targets may remain stale.
  - While rst_n=0, PredTakenF=0, PredTargetF=PCF+4 and MispredictE=0 combinationally.
  - Reset asserted alongside UpdateE: reset wins and no entry is written.
- Aliasing: a different PC with the same index misses. If taken, it evicts the existing entry.
- Non-control instructions never assert UpdateE, so they never allocate.

Decomposition:
- Shared package btb_pkg holds:
  - typedef btb_entry_t (struct: valid, tag, target, ctr);
  - localparams CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3, and CTR_ALLOC=CTR_WT;
  - functions for index and tag extraction.
- One sub-module, sat_counter2: combinational next-count given current count and taken, with saturation. Instantiated once on the update path.
- Entry storage is a flop array inside branch_target_buffer, not an inferred RAM, because the design needs a combinational read and a synchronous clear of the valid bits.

Test Plan:
- Reset, then lookup PCF=0x100 -> PredTakenF=0, PredTargetF=0x104. Repeat after 20 random updates followed by reset -> same result.
- Update PCE=0x100, TakenE=1, PCTargetE=0x200 (PredTakenE=0) -> MispredictE=1, RedirectPCE=0x200. Next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x200, ctr=2.
- Two more taken updates on 0x100 (ctr 3 and saturated). Then three not-taken updates -> ctr 2,1,0, PredTakenF=0 after the second not-taken; the fourth not-taken keeps ctr=0. A not-taken update with PredTakenE=1 -> MispredictE=1, RedirectPCE=0x104.
- JALR at PCE=0x300, same direction but PCTargetE=0x480 vs PredTargetE=0x400 -> MispredictE=1, RedirectPCE=0x480, stored target becomes 0x480.
- Alias: allocate 0x100->0x200, then taken update at 0x140 (same index, INDEX_BITS=4) -> PCF=0x100 misses, PCF=0x140 hits with its own target.
- Same-cycle: PCF=0x500 with taken update PCE=0x500 -> PredTakenF=0 in that cycle, 1 in the next. UpdateE=1 with rst_n=0 -> no allocation afterwards.
